y_pulse_counter: RTL and testbench
==================================

Name: y_pulse_counter

Overview:
Modulo event counter that sits directly downstream of the sequence generator. It consumes the generator's Y output and counts Y events, up or down, modulo MOD. It provides a registered terminal-count pulse and a sticky wrap flag for the next counter stage or for status logic. Supports synchronous clear, parallel load and an optional rising-edge qualification of Y.

Parameters:
WIDTH, 4, counter width in bits
MOD, 10, count range 0..MOD-1; legal range 2 <= MOD <= 2^WIDTH
EDGE, 0, 0 = count every cycle y_in is high; 1 = count only rising edges of y_in

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
y_in  input  1  Y from sequence generator, sampled on clk rising edge
en  input  1  count enable; gates events only
up  input  1  1 = increment, 0 = decrement
clr  input  1  synchronous clear
load  input  1  synchronous parallel load
load_val  input  WIDTH  value for load
count  output  WIDTH  current count, registered
tc  output  1  registered one-cycle terminal-count (wrap) pulse
ovf  output  1  sticky: at least one wrap since last clear/reset

Behaviour:
- Reset (rst=1, asynchronous, independent of clk):
  - count=0, tc=0, ovf=0, internal y_d=0.
  - Held while rst=1; first update on the first clk edge after release.
- Edge detect:
  - y_d <= y_in on every clk edge (not gated by en, clr or load).
  - edge = y_in & ~y_d.
- Event definition: evt = en & (EDGE ? edge : y_in).
- Per-edge priority: clr > load > evt > hold.
- clr=1:
  - count<=0, tc<=0, ovf<=0.
  - Concurrent load/evt ignored.
- load=1 (clr=0):
  - count<=load_val if load_val<=MOD-1, else count<=MOD-1 (clamp).
  - tc<=0; ovf unchanged; concurrent evt discarded, not deferred.
- evt=1 with up=1:
  - count==MOD-1 -> count<=0, tc<=1, ovf<=1.
  - Otherwise count<=count+1, tc<=0.
- evt=1 with up=0:
  - count==0 -> count<=MOD-1, tc<=1, ovf<=1.
  - Otherwise count<=count-1, tc<=0.
- No event: count holds, tc<=0, ovf holds.
- Timing:
  - Latency one clk from sampled y_in to count update.
  - tc is high in exactly the cycle count shows the wrapped value.
  - Back-to-back wrap events give back-to-back tc pulses.
- up may change every cycle; direction is applied per event with no pipeline.
- count never leaves 0..MOD-1 after reset, including when MOD < 2^WIDTH.
- Reset asserted mid-operation (between edges) zeroes all outputs immediately; no partial update completes.
- Generator output is one-cycle-high per 3 cycles with X held high. For that stream EDGE=0 and EDGE=1 give identical counts. They differ only when y_in stays high for multiple cycles.

Test Plan:
- Async reset: count=5, ovf=1, assert rst mid-cycle (no clk edge) -> count=0, tc=0, ovf=0 immediately; stays 0 while rst=1.
- Generator-driven up count: X held 1 so y_in pulses every 3rd cycle, en=1, up=1, EDGE=0, 10 pulses -> count 0..9 then 0 on 10th pulse; tc high that one cycle only; ovf=1.
- Down wrap: count=0, up=0, single y_in pulse -> count=9, tc=1 for one cycle, ovf=1. Next pulse -> count=8, tc=0, ovf stays 1.
- Load priority and clamp:
  - load=1, load_val=7, y_in=1 same edge -> count=7 (event dropped), tc=0.
  - load_val=12 -> count=9.
  - clr=1 with load=1 -> count=0, ovf=0.
- Edge mode: EDGE=1, y_in held high 4 cycles then low, en=1, up=1 from 3 -> count=4 (single increment). Same stimulus with EDGE=0 -> count=7.
- Enable gating: en=0 with 5 y_in pulses -> count unchanged, tc=0. Raise en while y_in already high with EDGE=1 -> no count (y_d already 1).

Source files
------------

// File: rtl/y_pulse_counter.sv
// Modulo-MOD up/down counter of Y events from the sequence generator, with a
// registered terminal-count pulse, a sticky wrap flag, clear and clamped load.
module y_pulse_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10,
  parameter int EDGE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y_in,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic             y_d;
  logic             y_rise;
  logic             evt;
  logic [WIDTH-1:0] count_n;
  logic             tc_n;
  logic             ovf_n;

  // y_d tracks y_in unconditionally so edge mode never sees a stale history
  // after a clear, load or disabled stretch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_d <= 1'b0;
    end else begin
      y_d <= y_in;
    end
  end

  assign y_rise = y_in & ~y_d;
  assign evt    = en & ((EDGE != 0) ? y_rise : y_in);

  // Priority: clr > load > evt > hold. tc is asserted only on a wrapping event.
  always_comb begin
    count_n = count;
    tc_n    = 1'b0;
    ovf_n   = ovf;
    if (clr) begin
      count_n = '0;
      ovf_n   = 1'b0;
    end else if (load) begin
      count_n = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (evt) begin
      if (up) begin
        if (count == MAX_VAL) begin
          count_n = '0;
          tc_n    = 1'b1;
          ovf_n   = 1'b1;
        end else begin
          count_n = count + ONE;
        end
      end else begin
        if (count == '0) begin
          count_n = MAX_VAL;
          tc_n    = 1'b1;
          ovf_n   = 1'b1;
        end else begin
          count_n = count - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_n;
      tc    <= tc_n;
      ovf   <= ovf_n;
    end
  end

endmodule

// File: tb/tb_y_pulse_counter.sv
// Bench for y_pulse_counter: three instances (level MOD=10, edge MOD=10,
// level MOD=16) driven in parallel and checked against a modulo-arithmetic model.
module tb_y_pulse_counter;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       y_in, en, up, clr, load;
  logic [3:0] load_val;
  logic [3:0] count0, count1, count2;
  logic       tc0, tc1, tc2, ovf0, ovf1, ovf2;

  always #5 clk = ~clk;

  y_pulse_counter #(.WIDTH(4), .MOD(10), .EDGE(0)) dut_lvl (
    .clk(clk), .rst(rst), .y_in(y_in), .en(en), .up(up), .clr(clr),
    .load(load), .load_val(load_val), .count(count0), .tc(tc0), .ovf(ovf0));

  y_pulse_counter #(.WIDTH(4), .MOD(10), .EDGE(1)) dut_edge (
    .clk(clk), .rst(rst), .y_in(y_in), .en(en), .up(up), .clr(clr),
    .load(load), .load_val(load_val), .count(count1), .tc(tc1), .ovf(ovf1));

  y_pulse_counter #(.WIDTH(4), .MOD(16), .EDGE(0)) dut_full (
    .clk(clk), .rst(rst), .y_in(y_in), .en(en), .up(up), .clr(clr),
    .load(load), .load_val(load_val), .count(count2), .tc(tc2), .ovf(ovf2));

  // ---------------- reference model ----------------
  int checks   = 0;
  int failures = 0;
  int m_count[3];
  bit m_tc[3];
  bit m_ovf[3];
  bit m_prev_y;

  function automatic int mod_of(int i);
    return (i == 2) ? 16 : 10;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_count[i] = 0;
      m_tc[i]    = 1'b0;
      m_ovf[i]   = 1'b0;
    end
    m_prev_y = 1'b0;
  endtask

  // One clock edge of the rules: events counted modulo MOD, wrap = crossing.
  task automatic model_step();
    int  m;
    bit  counted;
    bit  wrapped;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      m       = mod_of(i);
      counted = en && ((i == 1) ? (y_in && !m_prev_y) : y_in);
      m_tc[i] = 1'b0;
      if (clr) begin
        m_count[i] = 0;
        m_ovf[i]   = 1'b0;
      end else if (load) begin
        m_count[i] = (int'(load_val) < m) ? int'(load_val) : m - 1;
      end else if (counted) begin
        if (up) begin
          wrapped    = (m_count[i] + 1 >= m);
          m_count[i] = (m_count[i] + 1) % m;
        end else begin
          wrapped    = (m_count[i] == 0);
          m_count[i] = (m_count[i] + m - 1) % m;
        end
        m_tc[i]  = wrapped;
        m_ovf[i] = m_ovf[i] | wrapped;
      end
    end
    m_prev_y = y_in;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".count0"}, 32'(count0), 32'(m_count[0]));
    check({tag, ".tc0"},    32'(tc0),    32'(m_tc[0]));
    check({tag, ".ovf0"},   32'(ovf0),   32'(m_ovf[0]));
    check({tag, ".count1"}, 32'(count1), 32'(m_count[1]));
    check({tag, ".tc1"},    32'(tc1),    32'(m_tc[1]));
    check({tag, ".ovf1"},   32'(ovf1),   32'(m_ovf[1]));
    check({tag, ".count2"}, 32'(count2), 32'(m_count[2]));
    check({tag, ".tc2"},    32'(tc2),    32'(m_tc[2]));
    check({tag, ".ovf2"},   32'(ovf2),   32'(m_ovf[2]));
  endtask

  // ---------------- driver ----------------
  // Inputs change at posedge+1; outputs are sampled at posedge+1 after the step.
  task automatic tick(string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; y_in = 1'b0; en = 1'b0; up = 1'b1;
    clr = 1'b0; load = 1'b0; load_val = 4'd0;
    model_reset();
    #1;
    check_all("reset");
    check("reset_count", 32'(count0), 32'd0);
    tick("reset_hold");
    rst = 1'b0;

    // Generator stream: one-high-in-three, ten pulses -> 1..9 then wrap to 0.
    en = 1'b1; up = 1'b1;
    for (int p = 0; p < 10; p++) begin
      y_in = 1'b1;
      tick("gen");
      check("gen_count", 32'(count0), 32'((p + 1) % 10));
      check("gen_tc", 32'(tc0), (p == 9) ? 32'd1 : 32'd0);
      check("gen_edge_same", 32'(count1), 32'((p + 1) % 10));
      y_in = 1'b0;
      tick("gen_gap");
      check("gen_tc_gap", 32'(tc0), 32'd0);
      tick("gen_gap");
    end
    check("gen_ovf", 32'(ovf0), 32'd1);
    check("gen_ovf_mod16", 32'(ovf2), 32'd0);

    // Async reset from count=5, ovf=1, asserted between edges.
    load = 1'b1; load_val = 4'd5;
    tick("pre_rst_load");
    load = 1'b0;
    check("pre_rst_count", 32'(count0), 32'd5);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_count", 32'(count0), 32'd0);
    check("async_rst_ovf", 32'(ovf0), 32'd0);
    check_all("async_rst");
    y_in = 1'b1;
    tick("rst_held");
    tick("rst_held");
    rst = 1'b0; y_in = 1'b0;
    tick("rst_release");

    // Down wrap from 0.
    up = 1'b0; y_in = 1'b1;
    tick("down_wrap");
    check("down_wrap_count", 32'(count0), 32'd9);
    check("down_wrap_tc", 32'(tc0), 32'd1);
    check("down_wrap_ovf", 32'(ovf0), 32'd1);
    check("down_wrap_mod16", 32'(count2), 32'd15);
    y_in = 1'b0;
    tick("down_gap");
    check("down_tc_drop", 32'(tc0), 32'd0);
    y_in = 1'b1;
    tick("down_next");
    check("down_next_count", 32'(count0), 32'd8);
    check("down_next_ovf", 32'(ovf0), 32'd1);
    y_in = 1'b0;
    tick("down_idle");

    // Load priority, clamp and clear-over-load.
    up = 1'b1; load = 1'b1; load_val = 4'd7; y_in = 1'b1;
    tick("load_evt");
    check("load_evt_count", 32'(count0), 32'd7);
    check("load_evt_tc", 32'(tc0), 32'd0);
    load_val = 4'd12; y_in = 1'b0;
    tick("load_clamp");
    check("load_clamp_count", 32'(count0), 32'd9);
    check("load_noclamp_mod16", 32'(count2), 32'd12);
    clr = 1'b1;
    tick("clr_load");
    check("clr_load_count", 32'(count0), 32'd0);
    check("clr_load_ovf", 32'(ovf0), 32'd0);
    clr = 1'b0;

    // Back-to-back wraps with direction flipping per event.
    load_val = 4'd9;
    tick("b2b_load");
    load = 1'b0; y_in = 1'b1; up = 1'b1;
    tick("b2b_up");
    check("b2b_up_count", 32'(count0), 32'd0);
    check("b2b_up_tc", 32'(tc0), 32'd1);
    up = 1'b0;
    tick("b2b_down");
    check("b2b_down_count", 32'(count0), 32'd9);
    check("b2b_down_tc", 32'(tc0), 32'd1);
    up = 1'b1; y_in = 1'b0;
    tick("b2b_idle");

    // Edge vs level with y_in held high four cycles from count 3.
    load = 1'b1; load_val = 4'd3;
    tick("edge_load");
    load = 1'b0; y_in = 1'b1;
    for (int k = 0; k < 4; k++) tick("edge_hold");
    y_in = 1'b0;
    tick("edge_low");
    check("edge_mode_count", 32'(count1), 32'd4);
    check("level_mode_count", 32'(count0), 32'd7);

    // Enable gating.
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      y_in = 1'b1;
      tick("en_off");
      check("en_off_count", 32'(count0), 32'd7);
      check("en_off_tc", 32'(tc0), 32'd0);
      y_in = 1'b0;
      tick("en_off_gap");
    end
    y_in = 1'b1;
    tick("en_pre");
    en = 1'b1;
    tick("en_late");
    check("en_late_edge", 32'(count1), 32'd4);
    check("en_late_level", 32'(count0), 32'd8);
    y_in = 1'b0;
    tick("en_late_idle");

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      y_in     = 1'($urandom_range(0, 1));
      en       = ($urandom_range(0, 3) != 0);
      up       = 1'($urandom_range(0, 1));
      clr      = ($urandom_range(0, 40) == 0);
      load     = ($urandom_range(0, 15) == 0);
      load_val = 4'($urandom_range(0, 15));
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
